robsmult_n: RTL and testbench
=============================

# robsmult_n

Parametrised sequential Robertson's multiplier: a WIDTH×WIDTH shift-add multiplier with a runtime signed/unsigned mode and a start/busy/done handshake. It is the drop-in successor to the fixed 8-bit signed multiplier instantiated under the top-level multiplier wrapper, and is intended for the same top-level and testbench. One multiplier bit is retired per clock; the result is held until the next operation completes.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a multiplication; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplier  input  WIDTH  operand Q; sampled with start.
- multiplicand  input  WIDTH  operand M; sampled with start.
- product  output  2*WIDTH  registered result; holds its value between completions.
- done  output  1  one-cycle pulse: product is valid and newly updated.
- busy  output  1  high while an operation is in progress.

## Operation
- States: IDLE, CALC. The reset state is IDLE.
- IDLE with start=1:
  - Latch the mode bit smode and M_ext (WIDTH+1 bits: M sign-extended if signed_mode, zero-extended otherwise).
  - Set A=0 (WIDTH+1 bits), Q=multiplier, count=0.
  - Go to CALC and set busy=1.
- IDLE with start=0: hold all state. done=0.
- CALC, one iteration per clock:
  - If Q[0]=1 and (count==WIDTH-1 and smode), A = A - M_ext (Robertson sign-bit correction).
  - Otherwise, if Q[0]=1, A = A + M_ext.
  - If Q[0]=0, A is unchanged.
  - Then shift {A,Q} right by 1. The new A MSB is the sum's MSB when smode=1 (arithmetic shift); it is 0 when smode=0.
  - count increments.
- Completion, at the iteration with count==WIDTH-1:
  - Register product = {A[WIDTH-1:0], Q} using the post-shift values.
  - done=1 for exactly one cycle; busy=0.
  - Return to IDLE.
- Arithmetic rules:
  - A is WIDTH+1 bits, so no intermediate overflow occurs in either mode.
  - The result always fits 2*WIDTH bits exactly; product is never truncated or saturated.
- start while busy=1 is ignored. Operand, mode and start changes during CALC have no effect.
- start asserted in the cycle where done=1 is accepted, because the FSM is already in IDLE.
- reset low at any time, including mid-CALC:
  - Immediately (asynchronously) force state=IDLE, product=0, done=0, busy=0, count=0, A=0, Q=0.
  - The in-flight operation is discarded.
  - The first start after reset deasserts behaves normally.

## Timing
- Reset values: product=0, done=0, busy=0.
- Let E0 be the rising edge at which start is sampled in IDLE.
- busy goes high after E0. Iterations occur on edges E1..E_WIDTH.
- At E_WIDTH: product updates, done goes high, busy goes low.
- done is high only during the cycle between E_WIDTH and E_WIDTH+1.
- Latency is WIDTH clocks from E0 to done/product valid.
- Minimum start-to-start spacing is WIDTH+1 clocks; start may be held high continuously.
- product changes only at a completion edge or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, signed_mode=1, multiplier=-128, multiplicand=-128 -> product=0x4000 and done exactly 8 clocks after the start edge. busy is high for exactly 8 cycles.
- WIDTH=8, signed: -3×5 -> 0xFFF1; 5×-3 -> 0xFFF1; 0×-1 -> 0x0000. Unsigned: 255×255 -> 0xFE01; 128×2 -> 0x0100.
- WIDTH=8, start held high continuously with operand pairs (7,6) then (-1,-1), signed -> product 0x002A, then 0x0001. done pulses are 9 clocks apart.
- WIDTH=8, second start pulse with different operands at cycle 3 of busy -> ignored. The first result is unchanged, and no extra done pulse occurs.
- WIDTH=8, reset driven low asynchronously, mid-cycle, during iteration 4 of 100×100 -> product=0, busy=0, done=0 immediately. No done pulse follows. Next start with 100×100 unsigned -> 0x2710.
- WIDTH=16, signed -32768×32767 -> 0xC0008000 after 16 clocks. Unsigned 65535×65535 -> 0xFFFE0001. Also run a random signed/unsigned sweep against a behavioural reference model.

Source files
------------

// File: rtl/robsmult_n.sv
// robsmult_n: sequential Robertson shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One multiplier bit is retired per clock. Signed/unsigned mode is chosen per
// operation, and the result is held until the next operation completes.
module robsmult_n #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;       // partial product, one guard bit
  logic [WIDTH:0]     m_q, m_d;       // extended multiplicand
  logic [WIDTH-1:0]   q_q, q_d;       // multiplier, shifted right each step
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               smode_q, smode_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     sum;
  logic               last;

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      smode_q   <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      smode_q   <= smode_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: load operands in IDLE, one add/subtract-and-shift per CALC cycle.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    smode_d   = smode_q;
    product_d = product_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    sum       = a_q;
    last      = (cnt_q == LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          smode_d = signed_mode;
          m_d     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // The final signed step weighs the multiplier sign bit negatively.
        if (q_q[0])
          sum = (last && smode_q) ? (a_q - m_q) : (a_q + m_q);
        // Unsigned: the guard bit is a carry, so shift in zero.
        a_d   = {smode_q & sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          product_d = {a_d[WIDTH-1:0], q_d};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_robsmult_n.sv
// tb_robsmult_n: exercises an 8-bit and a 16-bit robsmult_n against an
// arithmetic reference model (plain signed/unsigned multiply).
module tb_robsmult_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic        smode = 1'b0;
  logic [31:0] mplier = '0, mcand = '0;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic        done8, busy8, done16, busy16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  robsmult_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(smode),
    .multiplier(mplier[7:0]), .multiplicand(mcand[7:0]),
    .product(prod8), .done(done8), .busy(busy8)
  );

  robsmult_n #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(smode),
    .multiplier(mplier[15:0]), .multiplicand(mcand[15:0]),
    .product(prod16), .done(done16), .busy(busy16)
  );

  // Reference: true product of the operands, as 2w-bit two's complement.
  function automatic logic [63:0] ref_mul(int w, bit sm, logic [31:0] q, logic [31:0] m);
    logic signed [63:0] qs, ms;
    logic [63:0] mask, r;
    mask = (64'd1 << w) - 64'd1;
    qs = {32'd0, q} & mask;
    ms = {32'd0, m} & mask;
    if (sm) begin
      qs = (qs <<< (64 - w)) >>> (64 - w);
      ms = (ms <<< (64 - w)) >>> (64 - w);
    end
    r = qs * ms;
    return r & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Start one operation on the selected DUT; report product, latency, busy cycles.
  task automatic run_op(input bit w16, input bit sm, input logic [31:0] qv, input logic [31:0] mv,
                        output logic [63:0] prod, output int lat, output int bcnt);
    @(negedge clk);
    smode = sm; mplier = qv; mcand = mv;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    lat = -1; bcnt = 0; prod = '0;
    if (w16 ? busy16 : busy8) bcnt++;
    for (int i = 1; i <= 40; i++) begin
      if (lat < 0) begin
        @(posedge clk); #1;
        if (w16 ? done16 : done8) begin
          lat  = i;
          prod = w16 ? {32'd0, prod16} : {48'd0, prod8};
        end else if (w16 ? busy16 : busy8) bcnt++;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    total++; if (prod8 !== 16'd0) begin bad++; $display("FAIL reset_prod8 got=%h exp=0", prod8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    total++; if (prod16 !== 32'd0) begin bad++; $display("FAIL reset_prod16 got=%h exp=0", prod16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL reset_done16 got=%b exp=0", done16); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_corners8;
    bit          sm_t[6] = '{1, 1, 1, 1, 0, 0};
    logic [31:0] q_t[6]  = '{32'h80, 32'hFD, 32'h05, 32'h00, 32'hFF, 32'h80};
    logic [31:0] m_t[6]  = '{32'h80, 32'h05, 32'hFD, 32'hFF, 32'hFF, 32'h02};
    logic [63:0] e_t[6]  = '{64'h4000, 64'hFFF1, 64'hFFF1, 64'h0000, 64'hFE01, 64'h0100};
    logic [63:0] p;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, sm_t[i], q_t[i], m_t[i], p, lat, bc);
      total++; if (p !== e_t[i]) begin bad++; $display("FAIL corner8_%0d_prod got=%h exp=%h", i, p, e_t[i]); end
      total++; if (lat != 8) begin bad++; $display("FAIL corner8_%0d_latency got=%0d exp=8", i, lat); end
      total++; if (bc != 8) begin bad++; $display("FAIL corner8_%0d_busy_cycles got=%0d exp=8", i, bc); end
    end
  endtask

  task automatic test_back_to_back;
    int t_d[2];
    logic [15:0] p_d[2];
    int n = 0;
    @(negedge clk);
    smode = 1'b1; mplier = 32'd7; mcand = 32'd6; start8 = 1'b1;
    @(posedge clk); #1;
    mplier = 32'hFF; mcand = 32'hFF;
    for (int t = 1; t <= 40; t++) begin
      if (n < 2) begin
        @(posedge clk); #1;
        if (done8) begin t_d[n] = t; p_d[n] = prod8; n++; end
      end
    end
    start8 = 1'b0;
    total++; if (n != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", n); end
    else begin
      total++; if (t_d[0] != 8) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=8", t_d[0]); end
      total++; if (p_d[0] !== 16'h002A) begin bad++; $display("FAIL b2b_first_prod got=%h exp=002a", p_d[0]); end
      total++; if (p_d[1] !== 16'h0001) begin bad++; $display("FAIL b2b_second_prod got=%h exp=0001", p_d[1]); end
      total++; if (t_d[1] - t_d[0] != 9) begin bad++; $display("FAIL b2b_spacing got=%0d exp=9", t_d[1] - t_d[0]); end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int ndone = 0, tfirst = -1;
    logic [15:0] pfirst = '0;
    @(negedge clk);
    smode = 1'b0; mplier = 32'd12; mcand = 32'd11; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (tfirst < 0) begin tfirst = t; pfirst = prod8; end
      end
      if (t == 2) begin mplier = 32'd200; mcand = 32'd200; start8 = 1'b1; end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    total++; if (tfirst != 8) begin bad++; $display("FAIL ign_latency got=%0d exp=8", tfirst); end
    total++; if (pfirst !== 16'd132) begin bad++; $display("FAIL ign_prod got=%0d exp=132", pfirst); end
    total++; if (prod8 !== 16'd132) begin bad++; $display("FAIL ign_prod_hold got=%0d exp=132", prod8); end
  endtask

  task automatic test_async_reset;
    int ndone = 0;
    int lat, bc;
    logic [63:0] p;
    @(negedge clk);
    smode = 1'b0; mplier = 32'd100; mcand = 32'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3; reset = 1'b0;
    #1;
    total++; if (prod8 !== 16'd0) begin bad++; $display("FAIL areset_prod got=%h exp=0", prod8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL areset_done got=%b exp=0", done8); end
    @(negedge clk); reset = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL areset_activity got=%0d exp=0", ndone); end
    run_op(1'b0, 1'b0, 32'd100, 32'd100, p, lat, bc);
    total++; if (p !== 64'h2710) begin bad++; $display("FAIL areset_next_prod got=%h exp=2710", p); end
    total++; if (lat != 8) begin bad++; $display("FAIL areset_next_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_w16;
    logic [63:0] p;
    int lat, bc;
    run_op(1'b1, 1'b1, 32'h8000, 32'h7FFF, p, lat, bc);
    total++; if (p !== 64'hC0008000) begin bad++; $display("FAIL w16_signed_prod got=%h exp=c0008000", p); end
    total++; if (lat != 16) begin bad++; $display("FAIL w16_signed_latency got=%0d exp=16", lat); end
    total++; if (bc != 16) begin bad++; $display("FAIL w16_busy_cycles got=%0d exp=16", bc); end
    run_op(1'b1, 1'b0, 32'hFFFF, 32'hFFFF, p, lat, bc);
    total++; if (p !== 64'hFFFE0001) begin bad++; $display("FAIL w16_unsigned_prod got=%h exp=fffe0001", p); end
    total++; if (lat != 16) begin bad++; $display("FAIL w16_unsigned_latency got=%0d exp=16", lat); end
  endtask

  task automatic test_random;
    logic [63:0] p, e;
    int lat, bc;
    bit w16, sm;
    logic [31:0] q, m;
    for (int i = 0; i < 60; i++) begin
      w16 = (i % 2) == 1;
      sm  = 1'($urandom_range(0, 1));
      q   = $urandom;
      m   = $urandom;
      e   = ref_mul(w16 ? 16 : 8, sm, q, m);
      run_op(w16, sm, q, m, p, lat, bc);
      total++;
      if (p !== e || lat != (w16 ? 16 : 8)) begin
        bad++;
        $display("FAIL rand_%0d w16=%0d sm=%0d q=%h m=%h got=%h lat=%0d exp=%h", i, w16, sm, q, m, p, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners8();
    test_back_to_back();
    test_ignored_start();
    test_async_reset();
    test_w16();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
